// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO read-side packer.
package fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_PACK_N     = 4;
  localparam int unsigned DEF_TIMEOUT    = 16;

  typedef enum logic [1:0] {
    S_FILL,
    S_HOLD,
    S_FLUSH
  } state_e;

  // Mask with the low 'cnt' bits set; callers size-cast to their keep width.
  function automatic logic [31:0] keep_mask(input int unsigned cnt);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      m[i] = (i < cnt);
    end
    return m;
  endfunction

endpackage

// File: rtl/fifo_rd_out_reg.sv
// Single-entry valid/ready output register for the packer.
module fifo_rd_out_reg #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned KEEP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_data,
  input  logic [KEEP_W-1:0] load_keep,
  input  logic              m_ready,
  output logic              m_valid,
  output logic [WIDTH-1:0]  m_data,
  output logic [KEEP_W-1:0] m_keep,
  output logic              free
);

  logic              valid_q, valid_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [KEEP_W-1:0] keep_q, keep_d;

  assign free    = !valid_q || m_ready;
  assign m_valid = valid_q;
  assign m_data  = data_q;
  assign m_keep  = keep_q;

  // Load has priority over accept so a word can be replaced in the accepting cycle.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    keep_d  = keep_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      keep_d  = load_keep;
    end else if (valid_q && m_ready) begin
      valid_d = 1'b0;
    end
  end

  // Output register state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
    end
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// Drains the FIFO read port and packs PACK_N entries per output word;
// partial words are flushed on request or after TIMEOUT idle cycles.
// Optional statistics outputs enabled by FIFO_RD_PACKER_STATS_EN.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned PACK_N     = DEF_PACK_N,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                         rd_clk,
  input  logic                         rst_n,
  input  logic                         fifo_empty,
  input  logic [DATA_WIDTH-1:0]        fifo_dout,
  output logic                         fifo_rd_en,
  input  logic                         flush_req,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DATA_WIDTH*PACK_N-1:0] m_data,
  output logic [PACK_N-1:0]            m_keep
`ifdef FIFO_RD_PACKER_STATS_EN
  ,
  output logic [31:0]                  word_cnt,
  output logic [15:0]                  flush_cnt
`endif
);

  localparam int unsigned CW = $clog2(PACK_N) + 1;
  localparam int unsigned IW = $clog2(TIMEOUT + 1);
  localparam int unsigned WW = DATA_WIDTH * PACK_N;

  state_e          state_q, state_d;
  logic [CW-1:0]   acc_cnt_q, acc_cnt_d;
  logic            pend_q, pend_d;
  logic [IW-1:0]   idle_q, idle_d;
  logic [WW-1:0]   acc_q, acc_d;

  logic [CW-1:0]   cnt_eff;
  logic            full_now;
  logic            flush_trig;
  logic            move;
  logic            out_free;
  logic [WW-1:0]   move_data;
  logic [PACK_N-1:0] move_keep;

  // Entries held including the one arriving this cycle.
  assign cnt_eff    = acc_cnt_q + CW'(pend_q);
  assign full_now   = (cnt_eff == CW'(PACK_N));
  assign fifo_rd_en = !fifo_empty && (state_q == S_FILL) && (cnt_eff < CW'(PACK_N));
  assign flush_trig = (flush_req || (idle_q == IW'(TIMEOUT))) && (cnt_eff != '0);
  assign pend_d     = fifo_rd_en;

  // Capture, move decision and FSM next state. The arriving entry is written
  // into acc_d first, so a completing entry bypasses into the output register.
  always_comb begin
    acc_d   = acc_q;
    state_d = state_q;
    move    = 1'b0;
    for (int unsigned k = 0; k < PACK_N; k++) begin
      if (pend_q && (acc_cnt_q == CW'(k))) begin
        acc_d[k*DATA_WIDTH +: DATA_WIDTH] = fifo_dout;
      end
    end
    case (state_q)
      S_FILL: begin
        if (full_now) begin
          if (out_free) move = 1'b1;
          else          state_d = S_HOLD;
        end else if (flush_trig) begin
          state_d = S_FLUSH;
        end
      end
      S_HOLD: begin
        if (full_now && out_free) begin
          move    = 1'b1;
          state_d = S_FILL;
        end
      end
      S_FLUSH: begin
        if (full_now) begin
          if (out_free) begin
            move    = 1'b1;
            state_d = S_FILL;
          end else begin
            state_d = S_HOLD;
          end
        end else if (!pend_q && out_free) begin
          move    = 1'b1;
          state_d = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase
    acc_cnt_d = move ? '0 : cnt_eff;
    move_keep = PACK_N'(keep_mask(32'(cnt_eff)));
    move_data = acc_d;
    for (int unsigned k = 0; k < PACK_N; k++) begin
      if (!move_keep[k]) move_data[k*DATA_WIDTH +: DATA_WIDTH] = '0;
    end
  end

  // Idle counter: counts cycles with a partial accumulator and nothing arriving.
  always_comb begin
    idle_d = '0;
    if ((acc_cnt_q != '0) && !pend_q && fifo_empty) begin
      idle_d = (idle_q == IW'(TIMEOUT)) ? idle_q : idle_q + IW'(1);
    end
  end

  // Control and accumulator registers.
  always_ff @(posedge rd_clk) begin
    if (!rst_n) begin
      state_q   <= S_FILL;
      acc_cnt_q <= '0;
      pend_q    <= 1'b0;
      idle_q    <= '0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      acc_cnt_q <= acc_cnt_d;
      pend_q    <= pend_d;
      idle_q    <= idle_d;
      acc_q     <= acc_d;
    end
  end

  fifo_rd_out_reg #(
    .WIDTH  (WW),
    .KEEP_W (PACK_N)
  ) u_out_reg (
    .clk       (rd_clk),
    .rst_n     (rst_n),
    .load      (move),
    .load_data (move_data),
    .load_keep (move_keep),
    .m_ready   (m_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_keep    (m_keep),
    .free      (out_free)
  );

`ifdef FIFO_RD_PACKER_STATS_EN
  logic [31:0] word_cnt_q, word_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Accepted transfers and partial-word moves; both wrap.
  always_comb begin
    word_cnt_d  = word_cnt_q + 32'(m_valid && m_ready);
    flush_cnt_d = flush_cnt_q + 16'(move && !full_now);
  end

  // Statistics registers.
  always_ff @(posedge rd_clk) begin
    if (!rst_n) begin
      word_cnt_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      word_cnt_q  <= word_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign word_cnt  = word_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer; checks statistics when
// FIFO_RD_PACKER_STATS_EN is defined.
module tb_fifo_rd_packer;

  localparam int unsigned DW = 8;
  localparam int unsigned PN = 4;
  localparam int unsigned TO = 16;
  localparam int unsigned WW = DW * PN;

  typedef struct {
    logic [WW-1:0] data;
    logic [PN-1:0] keep;
  } exp_t;

  logic          rd_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_dout = '0;
  logic          fifo_rd_en;
  logic          flush_req = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [WW-1:0] m_data;
  logic [PN-1:0] m_keep;
`ifdef FIFO_RD_PACKER_STATS_EN
  logic [31:0]   word_cnt;
  logic [15:0]   flush_cnt;
`endif

  fifo_rd_packer #(
    .DATA_WIDTH (DW),
    .PACK_N     (PN),
    .TIMEOUT    (TO)
  ) dut (
    .rd_clk     (rd_clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .flush_req  (flush_req),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_keep     (m_keep)
`ifdef FIFO_RD_PACKER_STATS_EN
    ,
    .word_cnt   (word_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  always #5 rd_clk = ~rd_clk;

  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned cyc = 0;
  int unsigned pops = 0;
  int unsigned last_rd = 0;
  int unsigned first_valid = 0;
  int unsigned words_model = 0;
  int unsigned flush_model = 0;
  int unsigned ready_mode = 0;
  bit          arm_first = 1'b0;
  logic [7:0]  in_q[$];
  logic [7:0]  fq[$];
  exp_t        exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
  endtask

  // FIFO model: read data appears the cycle after an accepted read strobe.
  always @(posedge rd_clk) begin
    if (fifo_rd_en && fq.size() > 0) begin
      fifo_dout <= fq.pop_front();
      pops++;
      last_rd = cyc;
    end
    while (in_q.size() > 0) fq.push_back(in_q.pop_front());
    fifo_empty <= (fq.size() == 0);
    cyc++;
  end

  // Downstream ready pattern.
  always @(posedge rd_clk) begin
    #1;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
  end

  // Monitor: compares each accepted word against the scoreboard.
  always @(negedge rd_clk) begin
    exp_t e;
    if (rst_n) begin
      if (fifo_rd_en) chk("rd_en_while_empty", 64'(fifo_empty), 64'd0);
      if (m_valid && arm_first) begin
        first_valid = cyc;
        arm_first   = 1'b0;
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_word: got data 0x%0h keep 0x%0h expected no word", m_data, m_keep);
        end else begin
          e = exp_q.pop_front();
          chk("word_data", 64'(m_data), 64'(e.data));
          chk("word_keep", 64'(m_keep), 64'(e.keep));
        end
      end
    end
  end

  // Reference packing: consecutive bytes in groups of PN, remainder as a partial word.
  task automatic model_phase(input logic [7:0] b[$]);
    exp_t e;
    int unsigned n;
    n = 0;
    e.data = '0;
    e.keep = '0;
    foreach (b[i]) begin
      e.data[n*DW +: DW] = b[i];
      e.keep[n] = 1'b1;
      n++;
      if (n == PN) begin
        exp_q.push_back(e);
        words_model++;
        n = 0;
        e.data = '0;
        e.keep = '0;
      end
    end
    if (n != 0) begin
      exp_q.push_back(e);
      words_model++;
      flush_model++;
    end
  endtask

  task automatic push_bytes(input logic [7:0] b[$], input int unsigned max_gap, input bit preload);
    if (preload) begin
      @(posedge rd_clk); #1;
      foreach (b[i]) in_q.push_back(b[i]);
    end else begin
      foreach (b[i]) begin
        @(posedge rd_clk); #1;
        in_q.push_back(b[i]);
        repeat ($urandom_range(0, max_gap)) @(posedge rd_clk);
      end
    end
  endtask

  task automatic pulse_flush();
    @(posedge rd_clk); #1 flush_req = 1'b1;
    @(posedge rd_clk); #1 flush_req = 1'b0;
  endtask

  task automatic wait_words(input int unsigned budget);
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge rd_clk);
      n++;
    end
    chk("words_left_after_drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_phase(input logic [7:0] b[$], input bit use_req,
                           input int unsigned max_gap, input bit preload);
    int unsigned n;
    model_phase(b);
    push_bytes(b, max_gap, preload);
    n = 0;
    while ((in_q.size() != 0 || !fifo_empty || fifo_rd_en) && n < 500) begin
      @(posedge rd_clk);
      n++;
    end
    repeat (3) @(posedge rd_clk);
    if (use_req) pulse_flush();
    wait_words(500);
    repeat (6) @(posedge rd_clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, expected the run to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  b[$];
    int unsigned p0;

    rst_n = 1'b0;
    repeat (3) @(posedge rd_clk);
    @(negedge rd_clk);
    chk("reset_m_valid", 64'(m_valid), 64'd0);
    chk("reset_m_keep", 64'(m_keep), 64'd0);
    chk("reset_m_data", 64'(m_data), 64'd0);
    chk("reset_rd_en", 64'(fifo_rd_en), 64'd0);
    @(posedge rd_clk); #1 rst_n = 1'b1;

    // Preloaded FIFO, continuous ready.
    ready_mode = 0;
    b = {};
    for (int i = 0; i < 8; i++) b.push_back(8'h11 + 8'(i));
    run_phase(b, 1'b0, 0, 1'b1);

    // Idle timeout flush of a three-entry partial word.
    b = {};
    b.push_back(8'hA1); b.push_back(8'hA2); b.push_back(8'hA3);
    arm_first = 1'b1;
    run_phase(b, 1'b0, 0, 1'b0);
    chk("timeout_latency", 64'(first_valid - last_rd), 64'(TO + 4));

    // Downstream stalled while 12 entries stream in.
    ready_mode = 2;
    b = {};
    for (int i = 0; i < 12; i++) b.push_back(8'h40 + 8'(i));
    model_phase(b);
    p0 = pops;
    push_bytes(b, 0, 1'b0);
    repeat (40) @(posedge rd_clk);
    @(negedge rd_clk);
    chk("stall_pops", 64'(pops - p0), 64'd8);
    chk("stall_rd_en", 64'(fifo_rd_en), 64'd0);
    chk("stall_valid", 64'(m_valid), 64'd1);
    chk("stall_data", 64'(m_data), 64'h43424140);
    chk("stall_keep", 64'(m_keep), 64'hF);
    ready_mode = 0;
    wait_words(200);
    repeat (6) @(posedge rd_clk);

    // Requested flush of two entries, then a flush with nothing held.
    p0 = pops;
    b = {};
    b.push_back(8'h01); b.push_back(8'h02);
    run_phase(b, 1'b1, 0, 1'b0);
    chk("flush_pops", 64'(pops - p0), 64'd2);
    pulse_flush();
    repeat (10) @(posedge rd_clk);
    @(negedge rd_clk);
    chk("empty_flush_no_valid", 64'(m_valid), 64'd0);

    // Reset mid-word: one word held in the output register, two in the accumulator.
    ready_mode = 2;
    b = {};
    for (int i = 0; i < 6; i++) b.push_back(8'h50 + 8'(i));
    push_bytes(b, 0, 1'b0);
    repeat (10) @(posedge rd_clk);
    @(negedge rd_clk);
    chk("pre_reset_valid", 64'(m_valid), 64'd1);
    @(posedge rd_clk); #1 rst_n = 1'b0;
    @(posedge rd_clk); #1 rst_n = 1'b1;
    @(negedge rd_clk);
    chk("post_reset_valid", 64'(m_valid), 64'd0);
    chk("post_reset_keep", 64'(m_keep), 64'd0);
    chk("post_reset_data", 64'(m_data), 64'd0);
    chk("post_reset_rd_en", 64'(fifo_rd_en), 64'd0);
    words_model = 0;
    flush_model = 0;
    ready_mode = 0;
    b = {};
    for (int i = 0; i < 4; i++) b.push_back(8'h31 + 8'(i));
    run_phase(b, 1'($urandom_range(0, 1)), 2, 1'b0);

    // Five full words plus one partial word.
    b = {};
    for (int i = 0; i < 22; i++) b.push_back(8'h60 + 8'(i));
    run_phase(b, 1'b1, 1, 1'b0);
`ifdef FIFO_RD_PACKER_STATS_EN
    chk("stats_word_cnt", 64'(word_cnt), 64'(words_model));
    chk("stats_flush_cnt", 64'(flush_cnt), 64'(flush_model));
`endif

    // Randomized phases.
    for (int ph = 0; ph < 25; ph++) begin
      int unsigned n;
      ready_mode = $urandom_range(0, 1);
      n = $urandom_range(1, 13);
      b = {};
      for (int unsigned i = 0; i < n; i++) b.push_back(8'($urandom));
      run_phase(b, 1'($urandom_range(0, 1)), 3, ($urandom_range(0, 3) == 0));
    end

`ifdef FIFO_RD_PACKER_STATS_EN
    chk("final_word_cnt", 64'(word_cnt), 64'(words_model));
    chk("final_flush_cnt", 64'(flush_cnt), 64'(flush_model));
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
